// File: rtl/ad7606_pkg.sv
// Shared types and widths for the AD7606 parallel-mode controller.
package ad7606_pkg;

    localparam int DATA_W = 16;
    localparam int CH_W   = 3;

    typedef enum logic [2:0] {
        RST,
        IDLE,
        CONV,
        WAIT_H,
        WAIT_L,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

endpackage

// File: rtl/ad7606_ctrl_sync2.sv
// Two-flop synchroniser used to bring the asynchronous BUSY line into sys_clk.
module sync2 (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-bus controller: periodic CONVST, BUSY handshake, 8-word read burst.
// Define AD_BUSY_TIMEOUT_EN to add a BUSY-wait timeout that re-resets the ADC.
module ad7606_ctrl
    import ad7606_pkg::*;
#(
    parameter int SMP_DIV   = 3300,
    parameter int RST_CYC   = 4,
    parameter int CONV_CYC  = 2,
    parameter int RD_LO_CYC = 2,
    parameter int RD_HI_CYC = 1,
    parameter int NUM_CH    = 8,
    parameter int CH_SEL    = 0,
    parameter int BUSY_TO   = 330
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ad_busy,
    input  logic [DATA_W-1:0] ad_db,
    output logic [2:0]        ad_os,
    output logic              ad_reset,
    output logic              ad_convst,
    output logic              ad_cs_n,
    output logic              ad_rd_n,
    output logic [DATA_W-1:0] ad_smp_data,
    output logic [CH_W-1:0]   ad_smp_ch,
    output logic              ad_smp_vld,
    output logic              ad_frame_done,
    output logic [DATA_W-1:0] ad_data,
    output logic              ad_ovr
);

    localparam logic [CH_W:0] LAST_CH = (CH_W + 1)'(NUM_CH - 1);
    localparam logic [CH_W:0] SEL_CH  = (CH_W + 1)'(CH_SEL);

    state_t            state;
    state_t            state_nxt;
    logic              busy_s;
    logic              tick;
    logic [15:0]       tick_cnt;
    logic [15:0]       cyc_cnt;
    logic [CH_W:0]     ch_cnt;
    logic              ch_clr;
    logic              ch_inc;
    logic              capture;
    logic              timeout;
    logic [DATA_W-1:0] sel_q;

    assign ad_os = 3'b000;

    sync2 u_busy_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (ad_busy),
        .q         (busy_s)
    );

    // Conversion pacing; parked at zero in RST so the first tick lands SMP_DIV cycles after IDLE entry.
    assign tick = (state != RST) && (tick_cnt == 16'(SMP_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (state == RST || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

`ifdef AD_BUSY_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt <= '0;
        end else if (state == WAIT_H || state == WAIT_L) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (state == WAIT_H || state == WAIT_L) && (to_cnt == 16'(BUSY_TO - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_clr    = 1'b0;
        ch_inc    = 1'b0;
        capture   = 1'b0;
        case (state)
            RST:    if (cyc_cnt == 16'(RST_CYC - 1)) state_nxt = IDLE;
            IDLE: begin
                if (tick) begin
                    state_nxt = CONV;
                    ch_clr    = 1'b1;
                end
            end
            CONV:   if (cyc_cnt == 16'(CONV_CYC - 1)) state_nxt = WAIT_H;
            WAIT_H: if (busy_s) state_nxt = WAIT_L;
            WAIT_L: if (!busy_s) state_nxt = RD_LO;
            RD_LO: begin
                if (cyc_cnt == 16'(RD_LO_CYC - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RD_HI;
                end
            end
            RD_HI: begin
                if (cyc_cnt == 16'(RD_HI_CYC - 1)) begin
                    ch_inc    = 1'b1;
                    state_nxt = (ch_cnt == LAST_CH) ? DONE : RD_LO;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = RST;
        endcase
        if (timeout) begin
            state_nxt = RST;
        end
    end

    // Dwell counter restarts on every state change, so each timed state sees 0..N-1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc_cnt <= '0;
        end else if (state_nxt != state) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ch_cnt <= '0;
        end else if (ch_clr) begin
            ch_cnt <= '0;
        end else if (ch_inc) begin
            ch_cnt <= ch_cnt + 1'b1;
        end
    end

    // ADC strobes are registered decodes of the next state so the pins never glitch.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ad_reset      <= 1'b1;
            ad_convst     <= 1'b1;
            ad_cs_n       <= 1'b1;
            ad_rd_n       <= 1'b1;
            ad_frame_done <= 1'b0;
            ad_smp_vld    <= 1'b0;
            ad_ovr        <= 1'b0;
            ad_smp_data   <= '0;
            ad_smp_ch     <= '0;
            sel_q         <= '0;
            ad_data       <= '0;
        end else begin
            ad_reset      <= (state_nxt == RST);
            ad_convst     <= (state_nxt != CONV);
            ad_cs_n       <= !(state_nxt == RD_LO || state_nxt == RD_HI);
            ad_rd_n       <= (state_nxt != RD_LO);
            ad_frame_done <= (state_nxt == DONE);
            ad_smp_vld    <= capture;
            ad_ovr        <= (tick && state != IDLE) || timeout;
            if (capture) begin
                ad_smp_data <= ad_db;
                ad_smp_ch   <= ch_cnt[CH_W-1:0];
                if (ch_cnt == SEL_CH) begin
                    sel_q <= ad_db;
                end
            end
            if (state_nxt == DONE) begin
                ad_data <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Directed bench for ad7606_ctrl: two lockstep instances (CH_SEL=0 and CH_SEL=3) on a shared ADC model.
module tb_ad7606_ctrl;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        ad_busy   = 1'b0;
    logic [15:0] ad_db     = 16'h0;

    logic [2:0]  ad_os0, ad_os3;
    logic        ad_reset0, ad_reset3;
    logic        ad_convst0, ad_convst3;
    logic        ad_cs_n0, ad_cs_n3;
    logic        ad_rd_n0, ad_rd_n3;
    logic [15:0] ad_smp_data0, ad_smp_data3;
    logic [2:0]  ad_smp_ch0, ad_smp_ch3;
    logic        ad_smp_vld0, ad_smp_vld3;
    logic        ad_frame_done0, ad_frame_done3;
    logic [15:0] ad_data0, ad_data3;
    logic        ad_ovr0, ad_ovr3;

    int vectors    = 0;
    int miscompares = 0;
    int pattern    = 0;
    int busy_len   = 100;
    bit busy_stuck = 1'b0;
    int rd_idx     = 0;

    always #15 sys_clk = ~sys_clk;

    ad7606_ctrl #(.SMP_DIV(200), .CH_SEL(0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_busy(ad_busy), .ad_db(ad_db),
        .ad_os(ad_os0), .ad_reset(ad_reset0), .ad_convst(ad_convst0), .ad_cs_n(ad_cs_n0),
        .ad_rd_n(ad_rd_n0), .ad_smp_data(ad_smp_data0), .ad_smp_ch(ad_smp_ch0),
        .ad_smp_vld(ad_smp_vld0), .ad_frame_done(ad_frame_done0), .ad_data(ad_data0),
        .ad_ovr(ad_ovr0)
    );

    ad7606_ctrl #(.SMP_DIV(200), .CH_SEL(3)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_busy(ad_busy), .ad_db(ad_db),
        .ad_os(ad_os3), .ad_reset(ad_reset3), .ad_convst(ad_convst3), .ad_cs_n(ad_cs_n3),
        .ad_rd_n(ad_rd_n3), .ad_smp_data(ad_smp_data3), .ad_smp_ch(ad_smp_ch3),
        .ad_smp_vld(ad_smp_vld3), .ad_frame_done(ad_frame_done3), .ad_data(ad_data3),
        .ad_ovr(ad_ovr3)
    );

    function automatic logic [15:0] expData(input int pat, input int ch);
        if (pat == 1) begin
            return (ch == 3) ? 16'h00C9 : 16'(32'h2000 + ch);
        end
        return 16'(32'h1000 + ch);
    endfunction

    // BUSY rises two cycles after CONVST falls and stays high for busy_len cycles.
    always begin
        @(negedge ad_convst0);
        if (!busy_stuck) begin
            repeat (2) @(negedge sys_clk);
            ad_busy = 1'b1;
            repeat (busy_len) @(negedge sys_clk);
            ad_busy = 1'b0;
        end
    end

    always @(negedge ad_convst0 or negedge ad_rd_n0) begin
        if (!ad_rd_n0) begin
            ad_db  = expData(pattern, rd_idx);
            rd_idx = rd_idx + 1;
        end else begin
            rd_idx = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int pat, input int blen);
        pattern  = pat;
        busy_len = blen;
    endtask

    task automatic releaseReset();
        int cnt;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        cnt = 0;
        while (ad_reset0 && cnt < 20) begin
            cnt++;
            @(negedge sys_clk);
        end
        checkOutput("ad_reset_len", cnt, 4);
        cnt = 0;
        while (ad_convst0 && cnt < 1000) begin
            cnt++;
            @(negedge sys_clk);
        end
        checkOutput("idle_to_convst", cnt, 200);
    endtask

    task automatic runFrame(input logic [15:0] hold3, input int exp_ovr);
        int cnt, width, vld, fd, ovr, rdlo, cslo, rdpulse, csfall, badrun, run;
        logic prev_rd, prev_cs;
        cnt = 0;
        while (ad_convst0 && cnt < 1000) begin
            cnt++;
            @(negedge sys_clk);
        end
        checkOutput("convst_seen", ad_convst0, 0);
        width = 0;
        while (!ad_convst0 && width < 10) begin
            width++;
            @(negedge sys_clk);
        end
        checkOutput("convst_width", width, 2);
        {vld, fd, ovr, rdlo, cslo, rdpulse, csfall, badrun, run, cnt} = '0;
        prev_rd = 1'b1;
        prev_cs = 1'b1;
        while (fd == 0 && cnt < 2000) begin
            if (ad_smp_vld0) begin
                checkOutput("smp_ch", ad_smp_ch0, vld);
                checkOutput("smp_data", ad_smp_data0, expData(pattern, vld));
                if (vld == 7) checkOutput("ad_data_hold", ad_data3, hold3);
                vld++;
            end
            if (ad_ovr0) ovr++;
            if (!ad_rd_n0) begin
                rdlo++;
                run++;
                if (prev_rd) rdpulse++;
            end else begin
                if (!prev_rd && run != 2) badrun++;
                run = 0;
            end
            if (!ad_cs_n0) begin
                cslo++;
                if (prev_cs) csfall++;
            end
            if (!ad_rd_n0 && ad_cs_n0) badrun++;
            if (ad_frame_done0) fd++;
            prev_rd = ad_rd_n0;
            prev_cs = ad_cs_n0;
            @(negedge sys_clk);
            cnt++;
        end
        checkOutput("frame_done_cnt", fd, 1);
        checkOutput("smp_vld_cnt", vld, 8);
        checkOutput("rd_pulses", rdpulse, 8);
        checkOutput("rd_low_cycles", rdlo, 16);
        checkOutput("cs_low_cycles", cslo, 24);
        checkOutput("cs_falls", csfall, 1);
        checkOutput("bad_strobes", badrun, 0);
        checkOutput("ovr_cnt", ovr, exp_ovr);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_ad_reset", ad_reset0, 1);
        checkOutput("rst_convst", ad_convst0, 1);
        checkOutput("rst_cs_n", ad_cs_n0, 1);
        checkOutput("rst_rd_n", ad_rd_n0, 1);
        checkOutput("rst_smp_data", ad_smp_data0, 0);
        checkOutput("rst_smp_ch", ad_smp_ch0, 0);
        checkOutput("rst_smp_vld", ad_smp_vld0, 0);
        checkOutput("rst_frame_done", ad_frame_done0, 0);
        checkOutput("rst_ad_data", ad_data0, 0);
        checkOutput("rst_ovr", ad_ovr0, 0);
        checkOutput("ad_os", ad_os0, 0);

        releaseReset();
        applyStimulus(0, 100);
        runFrame(16'h0000, 0);
        checkOutput("f1_ad_data_sel0", ad_data0, 16'h1000);
        checkOutput("f1_ad_data_sel3", ad_data3, 16'h1003);

        applyStimulus(1, 100);
        runFrame(16'h1003, 0);
        checkOutput("f2_ad_data_sel0", ad_data0, 16'h2000);
        checkOutput("f2_ad_data_sel3", ad_data3, 16'h00C9);
        checkOutput("f2_alarm", ($signed(ad_data3) > 200), 1);

        applyStimulus(0, 100);
        runFrame(16'h00C9, 0);
        checkOutput("f3_ad_data_sel3", ad_data3, 16'h1003);

        applyStimulus(0, 250);
        runFrame(16'h1003, 1);
        checkOutput("f4_ad_data_sel0", ad_data0, 16'h1000);
        applyStimulus(0, 100);

        cnt = 0;
        while (!(!ad_rd_n0 && rd_idx == 5) && cnt < 1000) begin
            cnt++;
            @(negedge sys_clk);
        end
        checkOutput("rd_ch4_seen", rd_idx, 5);
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_cs_n", ad_cs_n0, 1);
        checkOutput("midrst_rd_n", ad_rd_n0, 1);
        checkOutput("midrst_ad_data", ad_data0, 0);
        checkOutput("midrst_ad_reset", ad_reset0, 1);
        checkOutput("midrst_smp_vld", ad_smp_vld0, 0);
        repeat (2) @(negedge sys_clk);
        releaseReset();
        runFrame(16'h0000, 0);
        checkOutput("f6_ad_data_sel3", ad_data3, 16'h1003);

`ifdef AD_BUSY_TIMEOUT_EN
        begin
            int n, r, v;
            busy_stuck = 1'b1;
            cnt = 0;
            while (ad_convst0 && cnt < 1000) begin
                cnt++;
                @(negedge sys_clk);
            end
            while (!ad_convst0 && cnt < 1010) begin
                cnt++;
                @(negedge sys_clk);
            end
            n = 0;
            v = 0;
            while (!ad_reset0 && n < 1000) begin
                if (ad_smp_vld0) v++;
                n++;
                @(negedge sys_clk);
            end
            checkOutput("to_wait_cycles", n, 330);
            checkOutput("to_ovr", ad_ovr0, 1);
            r = 0;
            while (ad_reset0 && r < 20) begin
                r++;
                @(negedge sys_clk);
            end
            checkOutput("to_ad_reset_len", r, 4);
            checkOutput("to_smp_vld_cnt", v, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
